// File: rtl/dmi_jtag_dtm.sv
// JTAG Debug Transport Module: oversamples the JTAG pins in the clk domain,
// runs the TAP controller and the IDCODE/DTMCS/DMI/BYPASS registers, and
// turns Update-DR of the DMI register into one DMI request.
//
// DMI handshake: o_dmi_valid rises with addr/wdata/write stable and holds them
// until the cycle where o_dmi_valid && i_dmi_ready; valid drops on the next clk,
// and i_dmi_rdata is captured one clk after the match (reads only).
module dmi_jtag_dtm #(
    parameter logic [31:0] IDCODE = 32'h1000_0CFD
) (
    input  logic        i_clk,
    input  logic        i_resetn,
    input  logic        i_tck,
    input  logic        i_tms,
    input  logic        i_tdi,
    output logic        o_tdo,
    output logic        o_tdo_en,
    output logic        o_dmi_valid,
    input  logic        i_dmi_ready,
    output logic        o_dmi_write,
    output logic [6:0]  o_dmi_addr,
    output logic [31:0] o_dmi_wdata,
    input  logic [31:0] i_dmi_rdata,
    output logic [3:0]  o_tap_state,
    output logic [4:0]  o_ir,
    output logic [1:0]  o_dmi_state
);
    // TAP states use the IEEE 1149.1 reference encoding
    localparam logic [3:0] S_TLR = 4'hF, S_RTI = 4'hC, S_SDS = 4'h7, S_CDR = 4'h6,
                           S_SDR = 4'h2, S_E1D = 4'h1, S_PDR = 4'h3, S_E2D = 4'h0,
                           S_UDR = 4'h5, S_SIS = 4'h4, S_CIR = 4'hE, S_SIR = 4'hA,
                           S_E1I = 4'h9, S_PIR = 4'hB, S_E2I = 4'h8, S_UIR = 4'hD;
    localparam logic [4:0] IR_IDCODE = 5'h01, IR_DTMCS = 5'h10, IR_DMI = 5'h11;
    localparam logic [1:0] SEL_IDCODE = 2'd0, SEL_DTMCS = 2'd1, SEL_DMI = 2'd2, SEL_BYP = 2'd3;
    localparam logic [1:0] D_IDLE = 2'd0, D_REQ = 2'd1, D_RSP = 2'd2;

    logic        r_tck_s1, r_tck_s2, r_tck_s2_d, r_tms_s1, r_tms_s2, r_tdi_s1, r_tdi_s2;
    logic [3:0]  r_tap, w_tap_next;
    logic [4:0]  r_ir;
    logic [40:0] r_sr;
    logic        r_tdo;
    logic [1:0]  w_sel, r_sticky, r_dmi_state;
    logic        r_discard, r_valid, r_write;
    logic [6:0]  r_addr, r_last_addr;
    logic [31:0] r_wdata, r_last_rdata, w_dtmcs;
    logic        w_tck_rise, w_tck_fall, w_pending, w_upd_dr;
    logic [1:0]  w_status;

    assign w_tck_rise = r_tck_s2 & ~r_tck_s2_d;
    assign w_tck_fall = ~r_tck_s2 & r_tck_s2_d;
    assign w_pending  = (r_dmi_state != D_IDLE);
    assign w_status   = ((r_sticky != 2'd0) || w_pending) ? 2'd3 : 2'd0;
    assign w_upd_dr   = w_tck_fall && (r_tap == S_UDR);
    // dmireset/dmihardreset read back as 0; idle=1, dmistat=sticky, abits=7, version=1
    assign w_dtmcs    = {14'd0, 2'b00, 1'b0, 3'd1, r_sticky, 6'd7, 4'd1};

    // Two-flop synchronizers for the JTAG pins plus a delayed tck for edge detect
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_tck_s1 <= 1'b0; r_tck_s2 <= 1'b0; r_tck_s2_d <= 1'b0;
            r_tms_s1 <= 1'b0; r_tms_s2 <= 1'b0;
            r_tdi_s1 <= 1'b0; r_tdi_s2 <= 1'b0;
        end else begin
            r_tck_s1 <= i_tck; r_tck_s2 <= r_tck_s1; r_tck_s2_d <= r_tck_s2;
            r_tms_s1 <= i_tms; r_tms_s2 <= r_tms_s1;
            r_tdi_s1 <= i_tdi; r_tdi_s2 <= r_tdi_s1;
        end
    end

    // TAP next-state function driven by synchronized tms
    always_comb begin
        w_tap_next = r_tap;
        case (r_tap)
            S_TLR: w_tap_next = r_tms_s2 ? S_TLR : S_RTI;
            S_RTI: w_tap_next = r_tms_s2 ? S_SDS : S_RTI;
            S_SDS: w_tap_next = r_tms_s2 ? S_SIS : S_CDR;
            S_CDR: w_tap_next = r_tms_s2 ? S_E1D : S_SDR;
            S_SDR: w_tap_next = r_tms_s2 ? S_E1D : S_SDR;
            S_E1D: w_tap_next = r_tms_s2 ? S_UDR : S_PDR;
            S_PDR: w_tap_next = r_tms_s2 ? S_E2D : S_PDR;
            S_E2D: w_tap_next = r_tms_s2 ? S_UDR : S_SDR;
            S_UDR: w_tap_next = r_tms_s2 ? S_SDS : S_RTI;
            S_SIS: w_tap_next = r_tms_s2 ? S_TLR : S_CIR;
            S_CIR: w_tap_next = r_tms_s2 ? S_E1I : S_SIR;
            S_SIR: w_tap_next = r_tms_s2 ? S_E1I : S_SIR;
            S_E1I: w_tap_next = r_tms_s2 ? S_UIR : S_PIR;
            S_PIR: w_tap_next = r_tms_s2 ? S_E2I : S_PIR;
            S_E2I: w_tap_next = r_tms_s2 ? S_UIR : S_SIR;
            S_UIR: w_tap_next = r_tms_s2 ? S_SDS : S_RTI;
            default: w_tap_next = S_TLR;
        endcase
    end

    // Decode the instruction into the selected data register (unknown -> BYPASS)
    always_comb begin
        w_sel = SEL_BYP;
        case (r_ir)
            IR_IDCODE: w_sel = SEL_IDCODE;
            IR_DTMCS:  w_sel = SEL_DTMCS;
            IR_DMI:    w_sel = SEL_DMI;
            default:   w_sel = SEL_BYP;
        endcase
    end

    // TAP state register, advanced on tck rising strobes
    always_ff @(posedge i_clk) begin
        if (!i_resetn)       r_tap <= S_TLR;
        else if (w_tck_rise) r_tap <= w_tap_next;
    end

    // Instruction register: IDCODE whenever TLR is entered, loaded on Update-IR
    always_ff @(posedge i_clk) begin
        if (!i_resetn)                                r_ir <= IR_IDCODE;
        else if (w_tck_rise && (w_tap_next == S_TLR)) r_ir <= IR_IDCODE;
        else if (w_tck_fall && (r_tap == S_UIR))      r_ir <= r_sr[4:0];
    end

    // Shared IR/DR shift register: capture and shift on tck rise, tdo on tck fall
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_sr  <= '0;
            r_tdo <= 1'b0;
        end else begin
            if (w_tck_rise) begin
                case (r_tap)
                    S_CIR: r_sr <= {36'd0, 5'b00001};
                    S_SIR: r_sr <= {36'd0, r_tdi_s2, r_sr[4:1]};
                    S_CDR: begin
                        case (w_sel)
                            SEL_IDCODE: r_sr <= {9'd0, IDCODE};
                            SEL_DTMCS:  r_sr <= {9'd0, w_dtmcs};
                            SEL_DMI:    r_sr <= {r_last_addr, r_last_rdata, w_status};
                            default:    r_sr <= '0;
                        endcase
                    end
                    S_SDR: begin
                        case (w_sel)
                            SEL_DMI: r_sr <= {r_tdi_s2, r_sr[40:1]};
                            SEL_BYP: r_sr <= {40'd0, r_tdi_s2};
                            default: r_sr <= {9'd0, r_tdi_s2, r_sr[31:1]};
                        endcase
                    end
                    default: r_sr <= r_sr;
                endcase
            end
            if (w_tck_fall) r_tdo <= r_sr[0];
        end
    end

    // DTMCS/DMI update decisions and the DMI request/response FSM
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_dmi_state  <= D_IDLE;
            r_sticky     <= 2'd0;
            r_discard    <= 1'b0;
            r_valid      <= 1'b0;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_last_addr  <= '0;
            r_last_rdata <= '0;
        end else begin
            case (r_dmi_state)
                D_REQ: if (i_dmi_ready) begin
                    r_valid     <= 1'b0;
                    r_dmi_state <= D_RSP;
                end
                D_RSP: begin
                    if (!r_write && !r_discard) r_last_rdata <= i_dmi_rdata;
                    r_dmi_state <= D_IDLE;
                end
                default: r_dmi_state <= D_IDLE;
            endcase
            if (w_upd_dr && (w_sel == SEL_DTMCS)) begin
                if (r_sr[16] || r_sr[17]) r_sticky <= 2'd0;
                if (r_sr[17] && w_pending) r_discard <= 1'b1;
            end
            if (w_upd_dr && (w_sel == SEL_DMI) && (r_sticky == 2'd0)) begin
                if (w_pending) begin
                    r_sticky <= 2'd3;
                end else if ((r_sr[1:0] == 2'd1) || (r_sr[1:0] == 2'd2)) begin
                    r_valid     <= 1'b1;
                    r_write     <= (r_sr[1:0] == 2'd2);
                    r_addr      <= r_sr[40:34];
                    r_wdata     <= r_sr[33:2];
                    r_last_addr <= r_sr[40:34];
                    r_discard   <= 1'b0;
                    r_dmi_state <= D_REQ;
                end
            end
        end
    end

    assign o_tdo       = r_tdo;
    assign o_tdo_en    = (r_tap == S_SIR) || (r_tap == S_SDR);
    assign o_dmi_valid = r_valid;
    assign o_dmi_write = r_write;
    assign o_dmi_addr  = r_addr;
    assign o_dmi_wdata = r_wdata;
    assign o_tap_state = r_tap;
    assign o_ir        = r_ir;
    assign o_dmi_state = r_dmi_state;
endmodule

// File: tb/tb_dmi_jtag_dtm.sv
// Bench for dmi_jtag_dtm: drives JTAG scans, models a DM responder and
// predicts captured DR values and DMI requests from the DTM's register rules.
module tb_dmi_jtag_dtm;
  localparam logic [31:0] IDCODE = 32'h1000_0CFD;
  localparam logic [31:0] DTMCS_BASE = 32'h0000_1071;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn, tck, tms, tdi, tdo, tdo_en;
  logic dmi_valid, dmi_ready, dmi_write;
  logic [6:0] dmi_addr;
  logic [31:0] dmi_wdata, dmi_rdata;
  logic [3:0] tap_state;
  logic [4:0] ir;
  logic [1:0] dmi_state;

  always #5 clk = ~clk;

  dmi_jtag_dtm #(.IDCODE(IDCODE)) dut (
    .i_clk(clk), .i_resetn(resetn), .i_tck(tck), .i_tms(tms), .i_tdi(tdi),
    .o_tdo(tdo), .o_tdo_en(tdo_en), .o_dmi_valid(dmi_valid), .i_dmi_ready(dmi_ready),
    .o_dmi_write(dmi_write), .o_dmi_addr(dmi_addr), .o_dmi_wdata(dmi_wdata),
    .i_dmi_rdata(dmi_rdata), .o_tap_state(tap_state), .o_ir(ir), .o_dmi_state(dmi_state)
  );

  // ---------------- scoreboard / model state ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [39:0] exp_q[$];        // {write, addr, wdata} of each expected request
  logic [31:0] dm_mem [128];
  logic        hold_ready = 1'b0;
  logic        drop_chk = 1'b0;
  int          dly = 0;
  logic [1:0]  m_sticky = 2'd0;
  logic        m_pending = 1'b0;
  logic        m_discard = 1'b0;
  logic [6:0]  m_last_addr = '0;
  logic [31:0] m_last_rdata = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [40:0] m_capture();
    return {m_last_addr, m_last_rdata, ((m_sticky != 2'd0) || m_pending) ? 2'd3 : 2'd0};
  endfunction

  task automatic model_dmi_update(input logic [40:0] v);
    if (m_sticky != 2'd0) begin
    end else if (m_pending) begin
      m_sticky = 2'd3;
    end else if (v[1:0] == 2'd1 || v[1:0] == 2'd2) begin
      exp_q.push_back({v[1:0] == 2'd2, v[40:34], v[33:2]});
      m_last_addr = v[40:34];
      m_pending = 1'b1;
      m_discard = 1'b0;
    end
  endtask

  task automatic model_dtmcs_update(input logic [31:0] v);
    if (v[16] || v[17]) m_sticky = 2'd0;
    if (v[17] && m_pending) m_discard = 1'b1;
  endtask

  // ---------------- DM responder: ready-after-valid, random delay ----------------
  initial begin
    dmi_ready = 1'b0;
    dmi_rdata = '0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        dmi_ready = 1'b0;
        drop_chk = 1'b0;
      end else begin
        if (drop_chk) begin
          check_eq("valid_drop", 64'(dmi_valid), 64'(0));
          drop_chk = 1'b0;
        end
        if (dmi_ready) begin
          dmi_ready = 1'b0;
        end else if (dmi_valid && !hold_ready) begin
          if (dly == 0) begin
            logic [39:0] e;
            dmi_ready = 1'b1;
            dmi_rdata = dm_mem[dmi_addr];
            drop_chk = 1'b1;
            dly = $urandom_range(0, 3);
            check_eq("req_outstanding", 64'(exp_q.size()), 64'(1));
            if (exp_q.size() > 0) begin
              e = exp_q.pop_front();
              check_eq("dmi_req", 64'({dmi_write, dmi_addr, dmi_wdata}), 64'(e));
              if (e[39]) dm_mem[e[38:32]] = e[31:0];
              else if (!m_discard) m_last_rdata = dm_mem[e[38:32]];
              m_pending = 1'b0;
            end
          end else begin
            dly--;
          end
        end
      end
    end
  end

  // ---------------- JTAG driver tasks ----------------
  task automatic tck_pulse(input logic t_ms, input logic t_di);
    tms = t_ms;
    tdi = t_di;
    repeat (2) @(negedge clk);
    tck = 1'b1;
    repeat (6) @(negedge clk);
    tck = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic tap_reset();
    repeat (5) tck_pulse(1'b1, 1'b0);
    tck_pulse(1'b0, 1'b0);
  endtask

  // RTI -> Shift-DR, shift len bits, stop in Exit1-DR
  task automatic dr_shift(input int len, input logic [40:0] din, output logic [40:0] dout);
    dout = '0;
    tck_pulse(1'b1, 1'b0);
    tck_pulse(1'b0, 1'b0);
    tck_pulse(1'b0, 1'b0);
    for (int i = 0; i < len; i++) begin
      dout[i] = tdo;
      if (i == 0) check_eq("tdo_en_shift", 64'(tdo_en), 64'(1));
      tck_pulse(i == len - 1, din[i]);
    end
  endtask

  // Exit1 -> Update -> RTI
  task automatic xr_finish();
    tck_pulse(1'b1, 1'b0);
    tck_pulse(1'b0, 1'b0);
  endtask

  task automatic ir_set(input logic [4:0] val);
    logic [4:0] cap;
    cap = '0;
    tck_pulse(1'b1, 1'b0);
    tck_pulse(1'b1, 1'b0);
    tck_pulse(1'b0, 1'b0);
    tck_pulse(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cap[i] = tdo;
      tck_pulse(i == 4, val[i]);
    end
    xr_finish();
    check_eq("ir_capture", 64'(cap), 64'(5'b00001));
  endtask

  task automatic dmi_scan(input string tag, input logic [6:0] a, input logic [31:0] d,
                          input logic [1:0] op);
    logic [40:0] din, dout, exp;
    din = {a, d, op};
    exp = m_capture();
    dr_shift(41, din, dout);
    model_dmi_update(din);
    xr_finish();
    check_eq(tag, 64'(dout), 64'(exp));
  endtask

  task automatic dtmcs_scan(input string tag, input logic [31:0] v);
    logic [40:0] dout;
    logic [31:0] exp;
    ir_set(5'h10);
    exp = DTMCS_BASE | (32'(m_sticky) << 10);
    dr_shift(32, 41'(v), dout);
    model_dtmcs_update(v);
    xr_finish();
    check_eq(tag, 64'(dout[31:0]), 64'(exp));
    ir_set(5'h11);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000 && m_pending; i++) @(negedge clk);
    check_eq("idle_seen", 64'(m_pending), 64'(0));
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 300 && !dmi_valid; i++) @(negedge clk);
    check_eq("valid_seen", 64'(dmi_valid), 64'(1));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [40:0] dout;
    logic [6:0]  ra;
    for (int i = 0; i < 128; i++) dm_mem[i] = $urandom;
    dm_mem[7'h11] = 32'h1234_5678;
    resetn = 1'b0; tck = 1'b0; tms = 1'b0; tdi = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("rst_tap", 64'(tap_state), 64'(4'hF));
    check_eq("rst_ir", 64'(ir), 64'(5'h01));
    check_eq("rst_tdo", 64'({tdo, tdo_en}), 64'(0));
    check_eq("rst_dmi", 64'({dmi_valid, dmi_write, dmi_addr, dmi_wdata}), 64'(0));
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // IDCODE after TLR
    tap_reset();
    dr_shift(32, 41'd0, dout); xr_finish();
    check_eq("idcode", 64'(dout[31:0]), 64'(IDCODE));

    // DTMCS read
    ir_set(5'h10);
    dr_shift(32, 41'd0, dout); xr_finish();
    check_eq("dtmcs", 64'(dout[31:0]), 64'(DTMCS_BASE));

    // BYPASS and an unknown instruction both behave as 1-bit bypass
    ir_set(5'h1F);
    dr_shift(1, 41'd1, dout); xr_finish();
    check_eq("bypass_1bit", 64'(dout[0]), 64'(0));
    dr_shift(2, 41'b01, dout); xr_finish();
    check_eq("bypass_delay", 64'(dout[1:0]), 64'(2'b10));
    ir_set(5'h05);
    dr_shift(2, 41'b01, dout); xr_finish();
    check_eq("unknown_ir_bypass", 64'(dout[1:0]), 64'(2'b10));

    // TLR restores IDCODE
    tap_reset();
    check_eq("tlr_ir", 64'(ir), 64'(5'h01));
    dr_shift(32, 41'd0, dout); xr_finish();
    check_eq("idcode_again", 64'(dout[31:0]), 64'(IDCODE));

    // Directed DMI write then read
    ir_set(5'h11);
    dmi_scan("dmi_cap_wr", 7'h04, 32'hDEAD_BEEF, 2'd2);
    wait_idle();
    dmi_scan("dmi_cap_rd", 7'h11, 32'h0, 2'd1);
    wait_idle();
    dmi_scan("dmi_cap_after_rd", 7'h00, 32'h0, 2'd0);
    check_eq("rd_result", 64'(m_capture()), 64'({7'h11, 32'h1234_5678, 2'd0}));

    // Random DMI traffic
    for (int k = 0; k < 10; k++) begin
      dmi_scan("dmi_rand", 7'($urandom_range(0, 127)), $urandom, 2'($urandom_range(0, 3)));
      wait_idle();
    end
    dmi_scan("dmi_rand_final", 7'h00, 32'h0, 2'd0);

    // Busy: request held pending, second update makes sticky busy, then ignored
    hold_ready = 1'b1;
    ra = 7'($urandom_range(0, 127));
    dmi_scan("busy_first", ra, 32'h0, 2'd1);
    wait_valid();
    dmi_scan("busy_second", 7'h22, 32'h0, 2'd1);
    dmi_scan("busy_ignored", 7'h33, 32'hCAFE_F00D, 2'd2);
    hold_ready = 1'b0;
    wait_idle();
    dtmcs_scan("dtmcs_sticky", 32'h0001_0000);
    dmi_scan("after_dmireset", 7'h00, 32'h0, 2'd0);

    // dmihardreset while pending: request still completes, its data discarded
    hold_ready = 1'b1;
    ra = 7'($urandom_range(0, 127));
    dmi_scan("hard_first", ra, 32'h0, 2'd1);
    wait_valid();
    dtmcs_scan("dtmcs_hard", 32'h0002_0000);
    hold_ready = 1'b0;
    wait_idle();
    dmi_scan("after_hardreset", 7'h00, 32'h0, 2'd0);

    // resetn while dmi_valid is high
    hold_ready = 1'b1;
    dmi_scan("pre_reset", 7'h11, 32'h0, 2'd1);
    wait_valid();
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    check_eq("midrst_valid", 64'(dmi_valid), 64'(0));
    check_eq("midrst_tap", 64'(tap_state), 64'(4'hF));
    check_eq("midrst_ir", 64'(ir), 64'(5'h01));
    exp_q.delete();
    m_sticky = 2'd0; m_pending = 1'b0; m_discard = 1'b0;
    m_last_addr = '0; m_last_rdata = '0;
    hold_ready = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    tap_reset();
    ir_set(5'h11);
    dmi_scan("post_reset_cap", 7'h00, 32'h0, 2'd0);
    repeat (20) @(negedge clk);
    check_eq("no_extra_valid", 64'(dmi_valid), 64'(0));
    check_eq("exp_q_empty", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
